// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: grid cell status codes, pixel
// colours, grid coordinate widths and the renderer's internal types.
package snake_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SNAKE = 2'd1,
    ST_FOOD  = 2'd2,
    ST_WALL  = 2'd3
  } status_e;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } render_state_e;

  // Coordinates of an issued read plus a flag saying the slot is occupied.
  typedef struct packed {
    logic           valid;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pix_tag_t;

  function automatic logic [2:0] status_colour(input logic [1:0] status);
    case (status_e'(status))
      ST_EMPTY: return COL_BLACK;
      ST_SNAKE: return COL_GREEN;
      ST_FOOD:  return COL_RED;
      default:  return COL_WHITE;
    endcase
  endfunction

endpackage

// File: rtl/grid_scan_counter.sv
// Raster counter for the grid sweep: x runs fastest, y steps when x wraps.
// Flags the final cell (WIDTH-1, HEIGHT-1). WIDTH <= 256, HEIGHT <= 128.
module grid_scan_counter
  import snake_pkg::*;
#(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           x_last, y_last;

  // Compare at 32 bits so a full-range WIDTH/HEIGHT is never truncated.
  assign x_last = (32'(x_q) == 32'(WIDTH - 1));
  assign y_last = (32'(y_q) == 32'(HEIGHT - 1));

  // Next count: clear wins, otherwise advance x and carry into y.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_last && y_last;

endmodule

// File: rtl/grid_renderer.sv
// Sweeps the grid RAM once per start pulse and streams one coloured pixel
// per cycle to the VGA adapter. Define GRID_RENDER_BORDER_EN to force the
// outermost ring of pixels white regardless of cell status.
module grid_renderer
  import snake_pkg::*;
#(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 120,
  parameter int RAM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [X_W+Y_W-1:0]   ram_addr,
  input  logic [1:0]           ram_status,
  output logic [X_W-1:0]       x_out,
  output logic [Y_W-1:0]       y_out,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic                 busy,
  output logic                 done
);

  render_state_e  state_q, state_d;
  logic           scan_en, scan_clear, scan_last;
  logic [X_W-1:0] xc;
  logic [Y_W-1:0] yc;

  pix_tag_t       pipe_q [RAM_LATENCY];
  pix_tag_t       pipe_d [RAM_LATENCY];
  pix_tag_t       tail;
  logic           pipe_busy;
  logic           border_hit;
  logic [2:0]     pix_colour;

  logic [X_W-1:0] x_out_q, x_out_d;
  logic [Y_W-1:0] y_out_q, y_out_d;
  logic [2:0]     colour_q, colour_d;
  logic           plot_q, plot_d;

  grid_scan_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_scan (
    .clk  (clk),
    .reset(reset),
    .clear(scan_clear),
    .en   (scan_en),
    .x    (xc),
    .y    (yc),
    .last (scan_last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: start is only honoured in IDLE, nothing is queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (scan_last) state_d = DRAIN;
      DRAIN:   if (!pipe_busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: address only driven while scanning so idle reads are 0.
  always_comb begin
    scan_clear = (state_q == IDLE) && start;
    scan_en    = (state_q == SCAN);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    ram_addr   = scan_en ? {xc, yc} : '0;
  end

  // Delay line: coordinates ride alongside the RAM read so they meet the data.
  always_comb begin
    pipe_busy = 1'b0;
    pipe_d[0] = '{valid: scan_en, x: xc, y: yc};
    for (int i = 1; i < RAM_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    for (int i = 0; i < RAM_LATENCY; i++) pipe_busy = pipe_busy | pipe_q[i].valid;
  end

  // Delay line registers; reset drops any in-flight pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tail = pipe_q[RAM_LATENCY-1];

`ifdef GRID_RENDER_BORDER_EN
  assign border_hit = (tail.x == '0) || (32'(tail.x) == 32'(WIDTH - 1)) ||
                      (tail.y == '0) || (32'(tail.y) == 32'(HEIGHT - 1));
`else
  assign border_hit = 1'b0;
`endif

  // Pixel colour and output register load when the aligned slot is valid.
  always_comb begin
    pix_colour = border_hit ? COL_WHITE : status_colour(ram_status);
    x_out_d    = x_out_q;
    y_out_d    = y_out_q;
    colour_d   = colour_q;
    plot_d     = tail.valid;
    if (tail.valid) begin
      x_out_d  = tail.x;
      y_out_d  = tail.y;
      colour_d = pix_colour;
    end
  end

  // Pixel output registers feeding the VGA adapter.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_out_q  <= '0;
      y_out_q  <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      x_out_q  <= x_out_d;
      y_out_q  <= y_out_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign x_out  = x_out_q;
  assign y_out  = y_out_q;
  assign colour = colour_q;
  assign plot   = plot_q;

endmodule

// File: tb/tb_grid_renderer.sv
// Bench for grid_renderer: two instances (RAM latency 1 and 3) share start
// and reset, each with its own grid RAM model. Expected pixels, with the
// cycle each must appear on, are queued when a frame is started; negedge
// monitors pop and compare whenever plot or done is seen.
module tb_grid_renderer;

  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;
  localparam int NPIX   = WIDTH * HEIGHT;

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    logic        b;
    logic [31:0] t;
  } pix_t;

  logic        clk;
  logic        reset;
  logic        start;

  logic [14:0] addrA, addrB;
  logic [1:0]  stA, stB;
  logic [7:0]  xA, xB;
  logic [6:0]  yA, yB;
  logic [2:0]  colA, colB;
  logic        plotA, plotB, busyA, busyB, doneA, doneB;

  logic [1:0]  grid [0:32767];
  logic [14:0] addrB1, addrB2;

  pix_t        expQA[$], expQB[$];
  int          doneQA[$], doneQB[$];
  int          cyc;
  int          tests;
  int          fails;
  logic        doneSeenA, doneSeenB;

  grid_renderer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .RAM_LATENCY(1)) dutA (
    .clk(clk), .reset(reset), .start(start), .ram_addr(addrA), .ram_status(stA),
    .x_out(xA), .y_out(yA), .colour(colA), .plot(plotA), .busy(busyA), .done(doneA)
  );

  grid_renderer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .RAM_LATENCY(3)) dutB (
    .clk(clk), .reset(reset), .start(start), .ram_addr(addrB), .ram_status(stB),
    .x_out(xB), .y_out(yB), .colour(colB), .plot(plotB), .busy(busyB), .done(doneB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Grid RAM models: latency 1 and latency 3 read ports on the same contents.
  always @(posedge clk) begin
    stA    <= grid[addrA];
    addrB1 <= addrB;
    addrB2 <= addrB1;
    stB    <= grid[addrB2];
  end

  function automatic logic [2:0] refColour(input int x, input int y);
    logic [14:0] a;
    a = {x[7:0], y[6:0]};
`ifdef GRID_RENDER_BORDER_EN
    if (x == 0 || x == WIDTH - 1 || y == 0 || y == HEIGHT - 1) return 3'b111;
`endif
    case (grid[a])
      2'd0:    return 3'b000;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raster order, plot latency RAM_LATENCY+1 after address s+k, done one cycle after last pixel.
  task automatic pushFrame(input int s);
    pix_t p;
    int   k;
    for (int y = 0; y < HEIGHT; y++) begin
      for (int x = 0; x < WIDTH; x++) begin
        k   = y * WIDTH + x;
        p.x = x[7:0];
        p.y = y[6:0];
        p.c = refColour(x, y);
        p.b = 1'b1;
        p.t = 32'(s + 2 + k);
        expQA.push_back(p);
        p.t = 32'(s + 4 + k);
        expQB.push_back(p);
      end
    end
    doneQA.push_back(s + 2 + NPIX);
    doneQB.push_back(s + 4 + NPIX);
  endtask

  task automatic applyStimulus(input bit expectAccept);
    start = 1'b1;
    if (expectAccept) pushFrame(cyc + 1);
    tick();
    start = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 25000; i++) begin
      if (expQA.size() == 0 && expQB.size() == 0 && doneQA.size() == 0 && doneQB.size() == 0) break;
      tick();
    end
    checkOutput("frame_complete",
                64'(expQA.size() + expQB.size() + doneQA.size() + doneQB.size()), 64'd0);
    repeat (3) tick();
  endtask

  // Monitor for the latency-1 instance.
  always @(negedge clk) begin : monA
    pix_t e, a;
    int   t;
    if (plotA) begin
      if (expQA.size() == 0) checkOutput("plotA_unexpected", 64'd1, 64'd0);
      else begin
        e = expQA.pop_front();
        a = '{x: xA, y: yA, c: colA, b: busyA, t: 32'(cyc)};
        checkOutput("pixelA", 64'(a), 64'(e));
      end
    end
    if (doneSeenA) checkOutput("doneA_then_idle", 64'({doneA, busyA}), 64'd0);
    if (doneA) begin
      if (doneQA.size() == 0) checkOutput("doneA_unexpected", 64'd1, 64'd0);
      else begin
        t = doneQA.pop_front();
        checkOutput("doneA_cycle", 64'(cyc), 64'(t));
      end
    end
    doneSeenA = doneA;
  end

  // Monitor for the latency-3 instance.
  always @(negedge clk) begin : monB
    pix_t e, a;
    int   t;
    if (plotB) begin
      if (expQB.size() == 0) checkOutput("plotB_unexpected", 64'd1, 64'd0);
      else begin
        e = expQB.pop_front();
        a = '{x: xB, y: yB, c: colB, b: busyB, t: 32'(cyc)};
        checkOutput("pixelB", 64'(a), 64'(e));
      end
    end
    if (doneSeenB) checkOutput("doneB_then_idle", 64'({doneB, busyB}), 64'd0);
    if (doneB) begin
      if (doneQB.size() == 0) checkOutput("doneB_unexpected", 64'd1, 64'd0);
      else begin
        t = doneQB.pop_front();
        checkOutput("doneB_cycle", 64'(cyc), 64'(t));
      end
    end
    doneSeenB = doneB;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    doneSeenA = 1'b0;
    doneSeenB = 1'b0;
    reset     = 1'b1;
    start     = 1'b0;
    for (int i = 0; i < 32768; i++) grid[i] = 2'd0;

    repeat (3) tick();
    reset = 1'b0;

    // Idle with no start: everything stays quiet.
    repeat (20) begin
      @(negedge clk);
      checkOutput("idleA", 64'({plotA, busyA, doneA, addrA}), 64'd0);
      checkOutput("idleB", 64'({plotB, busyB, doneB, addrB}), 64'd0);
    end
    tick();

    // All-empty grid.
    applyStimulus(1'b1);
    waitIdle();

    // A few marked cells on an otherwise empty grid.
    grid[{8'd5, 7'd7}]     = 2'd1;
    grid[{8'd10, 7'd3}]    = 2'd2;
    grid[{8'd159, 7'd119}] = 2'd3;
    applyStimulus(1'b1);
    waitIdle();

    // Restart attempt mid-frame is ignored, then reset abandons the frame.
    applyStimulus(1'b1);
    repeat (499) tick();
    applyStimulus(1'b0);
    repeat (499) tick();
    reset = 1'b1;
    @(posedge clk);
    #1;
    expQA.delete();
    expQB.delete();
    doneQA.delete();
    doneQB.delete();
    @(negedge clk);
    checkOutput("abortA", 64'({plotA, busyA, doneA}), 64'd0);
    checkOutput("abortB", 64'({plotB, busyB, doneB}), 64'd0);
    reset = 1'b0;
    repeat (10) tick();

    // Fresh full frame over random contents.
    for (int i = 0; i < 32768; i++) grid[i] = 2'($urandom_range(0, 3));
    applyStimulus(1'b1);
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grid_renderer.md
Name: grid_renderer

Overview:
Reader side of the snake grid RAM. The game controller writes 2-bit cell status at address {x,y}. On each start pulse, this block sweeps every cell, reads its status, maps it to a 3-bit colour, and drives the VGA adapter pixel-write interface with one pixel per cycle. It sits between the grid RAM read port and vga_adapter.

Parameters:
WIDTH, 160, columns swept (x range 0..WIDTH-1)
HEIGHT, 120, rows swept (y range 0..HEIGHT-1)
RAM_LATENCY, 1, clock cycles from ram_addr change to valid ram_status; legal range 1..3

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to render one full frame
ram_addr  out  15  read address {x[7:0], y[6:0]} to the grid RAM
ram_status  in  2  cell status returned by the RAM, RAM_LATENCY cycles after ram_addr
x_out  out  8  pixel x to vga_adapter
y_out  out  7  pixel y to vga_adapter
colour  out  3  pixel colour to vga_adapter
plot  out  1  pixel write enable to vga_adapter
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last pixel is plotted

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: state=IDLE. ram_addr, x_out, y_out, colour, plot, busy, done are all 0. The scan counters and the pipeline valid bits are cleared.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE: when start=1, go to SCAN and zero the counters. start in any other state is ignored. There is no queuing.
  - SCAN: one address per cycle. ram_addr={xc,yc}. x increments first. At x=WIDTH-1, x wraps to 0 and y increments. After the address for (WIDTH-1, HEIGHT-1) is issued, go to DRAIN.
  - DRAIN: wait until the pipeline valid shift register is empty, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Pipeline: the issued {x,y} and a valid bit travel through a delay line of depth RAM_LATENCY. The output register captures ram_status aligned with its coordinates.
- Plot latency: plot for pixel (x,y) is asserted RAM_LATENCY+1 cycles after that address is issued.
- plot is high for exactly WIDTH*HEIGHT cycles per frame, contiguous, and plot never asserts outside a frame.
- Colour map: status 0 (empty) -> 3'b000 black. Status 1 (snake) -> 3'b010 green. Status 2 (food) -> 3'b100 red. Status 3 (wall) -> 3'b111 white.
- busy is high in SCAN, DRAIN, and DONE; it is low in IDLE.
- done and start coincident: start is accepted on the next cycle, when the FSM is back in IDLE.
- Reset mid-frame: the frame is abandoned immediately. plot=0 on the next cycle, and no done pulse is produced.
- Widths: compare counters against WIDTH-1 and HEIGHT-1 at full counter width, with no truncation. WIDTH must be ≤256 and HEIGHT ≤128.

Optional Feature:
GRID_RENDER_BORDER_EN
- Defined: pixels with x=0, x=WIDTH-1, y=0, or y=HEIGHT-1 are coloured 3'b111 regardless of ram_status. The RAM is still read for them, so timing is unchanged.
- Undefined: all pixels use the colour map only.

Decomposition:
- Shared package snake_pkg holds:
  - status codes ST_EMPTY=0, ST_SNAKE=1, ST_FOOD=2, ST_WALL=3;
  - colour constants COL_BLACK, COL_GREEN, COL_RED, COL_WHITE;
  - the X_W=8 and Y_W=7 widths.
- The controller uses the same status codes.
- One sub-module, grid_scan_counter: the x/y raster counter with enable, clear, and last-cell flag. The FSM, delay line, and colour map stay in grid_renderer.

Test Plan:
- Reset then idle 20 cycles, no start -> plot=0, busy=0, done=0, ram_addr=0 throughout.
- RAM model filled with status 0, one start pulse, RAM_LATENCY=1 -> first plot 2 cycles after first address; 19200 plot cycles with colour=000; done pulses exactly once; busy drops the cycle after done.
- Cells (5,7)=1, (10,3)=2, (159,119)=3, other cells 0 -> plots at those coordinates carry colours 010, 100, 111; all other plotted pixels carry 000.
- Repeat the previous scenario with RAM_LATENCY=3 -> identical pixel/colour sequence, shifted by 2 cycles.
- start re-pulsed at pixel 500, then reset asserted at pixel 1000 -> the second start is ignored; plot=0 the cycle after reset; no done; a new start gives a full 19200-pixel frame.
- With GRID_RENDER_BORDER_EN defined and all cells 0 -> pixels (0,50), (159,0), (80,119) are 111; pixel (80,60) is 000.
